hamming_enc_stream: RTL and testbench
=====================================

Name: hamming_enc_stream

Overview:
Streaming Hamming encoder that sits directly upstream of the Hamming decoder IP. It accepts IP_BIT-bit data words over a valid/ready handshake and computes the 4 even-parity bits. Each resulting (IP_BIT+4)-bit codeword is buffered in a small FIFO and presented over a valid/ready output, in the same bit format the decoder's IN_code port consumes.

Parameters:
IP_BIT, 9, data width; legal range 5..11, so that 4 parity bits cover all IP_BIT+4 positions.
DEPTH, 2, output FIFO entries; must be a power of two, minimum 2.

Ports:
clk  input  1  single clock; everything is sampled on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word this cycle.
in_data  input  IP_BIT  data word.
out_valid  output  1  out_code holds a valid codeword.
out_ready  input  1  downstream consumes out_code this cycle.
out_code  output  IP_BIT+4  codeword; MSB = Hamming position 1, LSB = position IP_BIT+4.
enc_cnt  output  8  number of codewords accepted; wraps modulo 256.

Behaviour:
- Reset: one cycle of rst high synchronously clears everything. FIFO count, read/write pointers and enc_cnt go to 0. out_valid=0, out_code=0, in_ready=1 on the cycle after reset.
- Reset mid-operation discards all buffered codewords; nothing is flushed.
- Codeword layout:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits fill the remaining positions in ascending order, in_data MSB first (in_data[IP_BIT-1] at position 3).
  - Parity bit p(2^k) = XOR of every data position whose index has bit k set, giving even parity.
- Accept: a word is accepted when in_valid && in_ready at a rising edge.
- Pop: a codeword is popped when out_valid && out_ready at a rising edge.
- in_ready = (count != DEPTH), taken from registered state only, with no combinational path from out_ready. A full FIFO therefore refuses input even while it is popping in the same cycle.
- out_valid = (count != 0). out_code = FIFO head, driven from registered storage. out_code is 0 when the FIFO is empty.
- Latency: a word accepted at edge N appears on out_code after edge N when the FIFO was empty (1 cycle). Otherwise it appears after all older entries have popped. Order is strict FIFO.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop with count == 0: impossible, because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- enc_cnt increments on every accept; 255+1 -> 0. It is not affected by pops.
- in_data is ignored when in_valid=0. out_code must hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: HAMMING_ERR_INJ_EN.
- When defined:
  - Ports inj_en (input, 1) and inj_pos (input, 4) are added.
  - On accept with inj_en=1 and 1 <= inj_pos <= IP_BIT+4, the bit at Hamming position inj_pos is inverted before the word is written to the FIFO.
  - inj_pos=0 or inj_pos > IP_BIT+4 leaves the codeword unchanged.
  - Sampling happens only on accept cycles.
- When undefined: the ports do not exist and the codeword is never modified.
- The purpose is to stimulate the decoder's single-bit correction.

Decomposition:
- Package hamming_pkg holds:
  - constant PAR_BITS=4;
  - function cw_width(IP_BIT) returning IP_BIT+4;
  - function hamming_encode(data) returning the codeword, which is shared with the decoder's verification model.
- Natural sub-module: hamming_fifo, a parameterised synchronous FIFO with count, full and empty. The encode function stays in the top module.

Test Plan (IP_BIT=9):
1. Reset: hold rst for 2 cycles -> out_valid=0, out_code=13'h0000, in_ready=1, enc_cnt=0.
2. Single word: in_data=9'h001 accepted at edge N -> after N: out_valid=1, out_code=13'h1221. With out_ready=1 it pops and out_valid=0 next cycle; enc_cnt=1.
3. Encoding values: in_data=9'h000 -> 13'h0000; in_data=9'h1FF -> 13'h0FFF.
4. Backpressure: out_ready=0, offer 9'h001, 9'h1FF, 9'h000 back-to-back -> the first two are accepted, in_ready=0 from the third cycle, and out_code holds at 13'h1221. When out_ready rises, the output is 13'h1221 then 13'h0FFF, and 9'h000 is accepted only after count drops.
5. Counter wrap: 256 accepts -> enc_cnt returns to 0. A reset asserted with 1 entry buffered -> out_valid=0 on the next cycle and the entry is lost.
6. HAMMING_ERR_INJ_EN defined:
   - in_data=9'h001, inj_en=1, inj_pos=13 -> 13'h1220.
   - inj_pos=1 -> 13'h0221.
   - inj_pos=14 -> 13'h1221.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants and the reference Hamming encode function.
// hamming_encode() is written for any data width up to IP_MAX so that the
// encoder RTL and the decoder's model can both call it with their own IP_BIT.
package hamming_pkg;

  localparam int PAR_BITS = 4;
  localparam int IP_MAX   = 11;
  localparam int CW_MAX   = IP_MAX + PAR_BITS;

  function automatic int cw_width(input int ip_bit);
    return ip_bit + PAR_BITS;
  endfunction

  // Returns the codeword right-aligned in CW_MAX bits: bit (cw-1) holds
  // Hamming position 1, bit 0 holds position cw. Data fills non-power-of-two
  // positions in ascending order, data MSB first; parity is even.
  function automatic logic [CW_MAX-1:0] hamming_encode(input int ip_bit,
                                                       input logic [IP_MAX-1:0] data);
    logic [CW_MAX:0]   pos;
    logic [CW_MAX-1:0] cw;
    logic              par;
    int                d;
    int                idx;
    pos = '0;
    cw  = '0;
    d   = ip_bit - 1;
    // scatter data bits onto the non-parity positions
    for (int p = 1; p <= CW_MAX; p++) begin
      if (p <= ip_bit + PAR_BITS && (p & (p - 1)) != 0) begin
        pos[p[3:0]] = data[d[3:0]];
        d = d - 1;
      end
    end
    // parity slots are still zero here, so they do not disturb each other
    for (int k = 0; k < PAR_BITS; k++) begin
      par = 1'b0;
      for (int p = 1; p <= CW_MAX; p++) begin
        if (p <= ip_bit + PAR_BITS && ((p >> k) & 1) != 0) begin
          par = par ^ pos[p[3:0]];
        end
      end
      idx = 1 << k;
      pos[idx[3:0]] = par;
    end
    // position 1 lands in the MSB of the codeword
    for (int p = 1; p <= CW_MAX; p++) begin
      if (p <= ip_bit + PAR_BITS) begin
        idx = ip_bit + PAR_BITS - p;
        cw[idx[3:0]] = pos[p[3:0]];
      end
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// hamming_fifo: small synchronous FIFO with occupancy count, full and empty.
// o_rdata is the raw head entry; pushes while full and pops while empty are
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module hamming_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // pointer and occupancy bookkeeping; push+pop together leaves count alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // storage needs no reset: an empty FIFO never exposes stale entries
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/hamming_enc_stream.sv
// hamming_enc_stream: streaming Hamming encoder feeding the Hamming decoder.
// Data words are encoded on accept and buffered in hamming_fifo; out_code is
// the registered FIFO head (zero while empty). in_ready depends only on the
// registered count, so a full FIFO refuses input even while it is popping.
// Optional error injection is compiled in with HAMMING_ERR_INJ_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds data stable while valid && !ready, ready never depends
// combinationally on valid.
module hamming_enc_stream
  import hamming_pkg::*;
#(
  parameter int IP_BIT = 9,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IP_BIT-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IP_BIT+PAR_BITS-1:0] out_code,
`ifdef HAMMING_ERR_INJ_EN
  input  logic                       inj_en,
  input  logic [3:0]                 inj_pos,
`endif
  output logic [7:0]                 enc_cnt
);

  localparam int CW = cw_width(IP_BIT);

  logic [CW-1:0]           w_enc;
  logic [CW-1:0]           w_flip;
  logic [CW-1:0]           w_wdata;
  logic [CW-1:0]           w_head;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_pop;
  logic [7:0]              r_enc_cnt;

  assign w_enc    = CW'(hamming_encode(IP_BIT, IP_MAX'(in_data)));
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_wdata  = w_enc ^ w_flip;

`ifdef HAMMING_ERR_INJ_EN
  // one-hot flip mask for Hamming position inj_pos (bit CW-inj_pos);
  // position 0 or beyond the codeword matches no bit
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < CW; i++) begin
      if (inj_en && (32'(inj_pos) == 32'(CW - i))) w_flip[i] = 1'b1;
    end
  end
`else
  assign w_flip = '0;
`endif

  hamming_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready  = !w_full;
  assign out_valid = (w_count != '0);
  assign out_code  = w_empty ? '0 : w_head;
  assign enc_cnt   = r_enc_cnt;

  // count accepted words, wrapping modulo 256; pops do not touch it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_cnt <= 8'd0;
    end else if (w_accept) begin
      r_enc_cnt <= r_enc_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// tb_hamming_enc_stream: scoreboard bench for hamming_enc_stream (IP_BIT=9,
// DEPTH=2). Inputs change and outputs are sampled on the falling edge.
module tb_hamming_enc_stream;

  localparam int IP_BIT = 9;
  localparam int DEPTH  = 2;
  localparam int CW     = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [8:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [12:0]   out_code;
  logic [7:0]    enc_cnt;
`ifdef HAMMING_ERR_INJ_EN
  logic          inj_en;
  logic [3:0]    inj_pos;
`endif

  logic [CW-1:0] exp_q[$];
  logic [7:0]    exp_cnt;
  int            acc_total;
  int            n_cmp;
  int            n_err;

  // clock / reset block
  always #5 clk = ~clk;

  hamming_enc_stream #(
    .IP_BIT (IP_BIT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
`ifdef HAMMING_ERR_INJ_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .enc_cnt   (enc_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference encoder from an explicit table of data positions
  function automatic logic [CW-1:0] model_enc(input logic [8:0] d);
    int            dpos [9] = '{3, 5, 6, 7, 9, 10, 11, 12, 13};
    logic [15:0]   b;
    logic [CW-1:0] r;
    int            idx;
    int            bi;
    b = '0;
    for (int j = 0; j < 9; j++) begin
      idx = dpos[j];
      bi  = 8 - j;
      b[idx[3:0]] = d[bi[3:0]];
      for (int k = 0; k < 4; k++) begin
        if (((dpos[j] >> k) & 1) != 0) begin
          idx = 1 << k;
          b[idx[3:0]] = b[idx[3:0]] ^ d[bi[3:0]];
        end
      end
    end
    for (int p = 1; p <= CW; p++) begin
      idx = CW - p;
      bi  = p;
      r[idx[3:0]] = b[bi[3:0]];
    end
`ifdef HAMMING_ERR_INJ_EN
    if (inj_en && inj_pos >= 4'd1 && inj_pos <= 4'd13) begin
      idx = CW - int'(inj_pos);
      r[idx[3:0]] = ~r[idx[3:0]];
    end
`endif
    return r;
  endfunction

  // driver: apply inputs at the falling edge, score the handshakes that the
  // next rising edge will perform, then advance one cycle
  task automatic step(input logic v, input logic [8:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    check("in_ready", in_ready, 32'(exp_q.size() != DEPTH));
    check("out_valid", out_valid, 32'(exp_q.size() != 0));
    check("enc_cnt", enc_cnt, exp_cnt);
    if (out_valid && exp_q.size() > 0) begin
      if (out_ready) check("out_code", out_code, exp_q.pop_front());
      else           check("out_code_hold", out_code, exp_q[0]);
    end else if (!out_valid) begin
      check("out_code_idle", out_code, 0);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model_enc(d));
      exp_cnt = exp_cnt + 8'd1;
      acc_total++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt   = 8'd0;
    acc_total = 0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_cnt   = 8'd0;
    acc_total = 0;
`ifdef HAMMING_ERR_INJ_EN
    inj_en  = 1'b0;
    inj_pos = 4'd0;
`endif
    @(negedge clk);

    // reset state
    do_reset(2);
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 13'h0000);
    check("rst_ready", in_ready, 1);
    check("rst_cnt", enc_cnt, 0);

    // single word, one-cycle latency, then pop
    step(1'b1, 9'h001, 1'b1);
    check("t2_valid", out_valid, 1);
    check("t2_code", out_code, 13'h1221);
    step(1'b0, 9'h000, 1'b1);
    check("t2_empty", out_valid, 0);
    check("t2_cnt", enc_cnt, 8'd1);

    // encoding corner values
    step(1'b1, 9'h000, 1'b1);
    check("t3_valid0", out_valid, 1);
    check("t3_code0", out_code, 13'h0000);
    step(1'b1, 9'h1FF, 1'b1);
    check("t3_code1ff", out_code, 13'h0FFF);
    step(1'b0, 9'h000, 1'b1);

    // backpressure: fill, hold, refuse, then drain in order
    step(1'b1, 9'h001, 1'b0);
    step(1'b1, 9'h1FF, 1'b0);
    check("t4_full_ready", in_ready, 0);
    check("t4_hold_code", out_code, 13'h1221);
    step(1'b1, 9'h000, 1'b0);
    step(1'b1, 9'h000, 1'b0);
    check("t4_still_hold", out_code, 13'h1221);
    step(1'b1, 9'h000, 1'b1);
    check("t4_second", out_code, 13'h0FFF);
    check("t4_ready_back", in_ready, 1);
    step(1'b1, 9'h000, 1'b1);
    check("t4_third", out_code, 13'h0000);
    step(1'b0, 9'h000, 1'b1);
    check("t4_drained", out_valid, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef HAMMING_ERR_INJ_EN
      inj_en  = 1'($urandom_range(0, 1));
      inj_pos = 4'($urandom_range(0, 15));
`endif
      step(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)));
    end
`ifdef HAMMING_ERR_INJ_EN
    inj_en = 1'b0;
`endif
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 9'h000, 1'b1);
    check("rand_drained", out_valid, 0);

    // enc_cnt wrap after 256 accepts since reset
    do_reset(1);
    for (int i = 0; i < 2000 && acc_total < 256; i++) step(1'b1, 9'($urandom), 1'b1);
    check("wrap_total", acc_total, 256);
    check("wrap_cnt", enc_cnt, 8'd0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 9'h000, 1'b1);

    // reset with one entry buffered discards it
    step(1'b1, 9'h0AA, 1'b0);
    check("mid_valid", out_valid, 1);
    do_reset(1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_code", out_code, 13'h0000);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_cnt", enc_cnt, 0);

`ifdef HAMMING_ERR_INJ_EN
    // error injection at last position, first position and out of range
    inj_en  = 1'b1;
    inj_pos = 4'd13;
    step(1'b1, 9'h001, 1'b1);
    check("inj13", out_code, 13'h1220);
    inj_pos = 4'd1;
    step(1'b1, 9'h001, 1'b1);
    check("inj1", out_code, 13'h0221);
    inj_pos = 4'd14;
    step(1'b1, 9'h001, 1'b1);
    check("inj14", out_code, 13'h1221);
    inj_en = 1'b0;
    step(1'b0, 9'h000, 1'b1);
    check("inj_drained", out_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
